// File: rtl/keccak_state_serializer.sv
`default_nettype none
// ============================================================================
// Module   : keccak_state_serializer
// Brief    : Streams a Keccak-f[1600] state array out as x-fastest 64-bit
//            lanes (S[64*(5y+x)+z] = A[x][y][z]) over valid/ready.
// Revision : 1.0 - initial release
// ============================================================================
module keccak_state_serializer #(
    parameter int LANE_W    = 64,
    parameter int NUM_LANES = 25
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        load_valid,
    output logic                        load_ready,
    input  logic [4:0][4:0][LANE_W-1:0] state_in,
    input  logic [4:0]                  num_lanes,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [LANE_W-1:0]           out_data,
    output logic [4:0]                  out_index,
    output logic                        out_last,
    output logic                        busy
);

    localparam logic [4:0] c_MAX_LANES = 5'(NUM_LANES);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SEND = 1'b1
    } state_t;

    state_t                      r_state;
    state_t                      w_state_next;
    logic [4:0][4:0][LANE_W-1:0] r_buf;
    logic [2:0]                  r_x;
    logic [2:0]                  r_y;
    logic [4:0]                  r_idx;
    logic [4:0]                  r_count;
    logic [4:0]                  w_count_clamped;
    logic                        w_load;
    logic                        w_beat;
    logic                        w_is_last;

    // Zero or out-of-range requests mean "the whole state".
    assign w_count_clamped = (num_lanes == 5'd0 || num_lanes > c_MAX_LANES)
                             ? c_MAX_LANES : num_lanes;
    assign w_is_last       = (r_idx == r_count - 5'd1);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        load_ready   = 1'b0;
        out_valid    = 1'b0;
        busy         = 1'b0;
        w_load       = 1'b0;
        w_beat       = 1'b0;
        case (r_state)
            S_IDLE: begin
                load_ready = ~reset;
                if (load_valid && !reset) begin
                    w_load       = 1'b1;
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                if (out_ready) begin
                    w_beat = 1'b1;
                    if (w_is_last) begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // x and y walk in lockstep with idx so the lane select needs no divider.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_buf   <= '0;
            r_x     <= 3'd0;
            r_y     <= 3'd0;
            r_idx   <= 5'd0;
            r_count <= 5'd0;
        end else if (w_load) begin
            r_buf   <= state_in;
            r_count <= w_count_clamped;
            r_x     <= 3'd0;
            r_y     <= 3'd0;
            r_idx   <= 5'd0;
        end else if (w_beat && !w_is_last) begin
            r_idx <= r_idx + 5'd1;
            if (r_x == 3'd4) begin
                r_x <= 3'd0;
                r_y <= r_y + 3'd1;
            end else begin
                r_x <= r_x + 3'd1;
            end
        end
    end

    assign out_data  = (r_state == S_SEND) ? r_buf[r_x][r_y] : '0;
    assign out_index = (r_state == S_SEND) ? r_idx : 5'd0;
    assign out_last  = (r_state == S_SEND) && w_is_last;

endmodule
`default_nettype wire

// File: tb/tb_keccak_state_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_keccak_state_serializer
// Brief    : Randomized self-checking bench for keccak_state_serializer.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_keccak_state_serializer;

    typedef logic [4:0][4:0][63:0] st_t;

    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    st_t         state_in   = '0;
    logic [4:0]  num_lanes  = 5'd0;
    logic        out_valid;
    logic        out_ready  = 1'b0;
    logic [63:0] out_data;
    logic [4:0]  out_index;
    logic        out_last;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;

    logic [63:0] got_data[$];
    int          got_idx[$];
    bit          got_last[$];
    bit          timed_out;
    bit          lr_after;
    int          stall_bad;

    always #5 clk = ~clk;

    keccak_state_serializer #(.LANE_W(64), .NUM_LANES(25)) dut (
        .clk        (clk),
        .reset      (reset),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .state_in   (state_in),
        .num_lanes  (num_lanes),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_index  (out_index),
        .out_last   (out_last),
        .busy       (busy)
    );

    // Reference: S[64*n + z] = A[n%5][n/5][z]
    function automatic logic [63:0] exp_lane(input st_t s, input int n);
        return s[n % 5][n / 5];
    endfunction

    function automatic int clamp(input int nl);
        return (nl == 0 || nl > 25) ? 25 : nl;
    endfunction

    function automatic st_t rand_state();
        st_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = {$urandom(), $urandom()};
        return s;
    endfunction

    task automatic do_load(input st_t s, input logic [4:0] nl);
        state_in   = s;
        num_lanes  = nl;
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
    endtask

    // Gathers handshaken beats until out_last; records load_ready one cycle later.
    task automatic collect(input bit rand_ready);
        logic [63:0] pd;
        logic [4:0]  pi;
        logic        pl;
        bit          stalled = 0;
        bit          done = 0;
        got_data.delete(); got_idx.delete(); got_last.delete();
        timed_out = 0; lr_after = 0; stall_bad = 0;
        pd = '0; pi = '0; pl = 1'b0;
        for (int c = 0; c < 400 && !done; c++) begin
            out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            if (out_valid) begin
                if (stalled && (out_data !== pd || out_index !== pi || out_last !== pl))
                    stall_bad++;
                if (out_ready) begin
                    got_data.push_back(out_data);
                    got_idx.push_back(int'(out_index));
                    got_last.push_back(out_last);
                    stalled = 0;
                    if (out_last) done = 1;
                end else begin
                    stalled = 1;
                    pd = out_data; pi = out_index; pl = out_last;
                end
            end
            @(negedge clk);
        end
        if (done) lr_after = load_ready;
        else      timed_out = 1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({out_valid, out_last, busy, load_ready} !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_ctrl: got valid/last/busy/load_ready=%b required 0000",
                     {out_valid, out_last, busy, load_ready});
        end
        n_cmp++;
        if (out_data !== 64'h0 || out_index !== 5'd0) begin
            n_err++;
            $display("FAIL reset_data: got data=%h index=%0d required 0/0", out_data, out_index);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL reset_release: got load_ready=%b required 1", load_ready);
        end
    endtask

    task automatic test_mapping();
        st_t s;
        for (int x = 0; x < 5; x++)
            for (int y = 0; y < 5; y++)
                s[x][y] = 64'h0100 * (5 * y + x) + 64'hA5;
        do_load(s, 5'd25);
        n_cmp++;
        if (out_valid !== 1'b1 || busy !== 1'b1) begin
            n_err++;
            $display("FAIL map_latency: got valid=%b busy=%b required 1/1", out_valid, busy);
        end
        collect(0);
        n_cmp++;
        if (timed_out || got_data.size() != 25) begin
            n_err++;
            $display("FAIL map_count: got %0d beats (timeout=%0d) required 25", got_data.size(), timed_out);
        end
        for (int n = 0; n < got_data.size(); n++) begin
            n_cmp++;
            if (got_data[n] !== 64'h0100 * n + 64'hA5 || got_idx[n] != n || got_last[n] != (n == 24)) begin
                n_err++;
                $display("FAIL map_beat%0d: got data=%h idx=%0d last=%0d required data=%h idx=%0d last=%0d",
                         n, got_data[n], got_idx[n], got_last[n], 64'h0100 * n + 64'hA5, n, (n == 24));
            end
        end
        n_cmp++;
        if (lr_after !== 1'b1) begin
            n_err++;
            $display("FAIL map_load_ready: got %b required 1", lr_after);
        end
    endtask

    task automatic test_bit_order();
        st_t s;
        logic [63:0] e;
        s = '0;
        s[1][0][0]  = 1'b1;
        s[0][1][63] = 1'b1;
        do_load(s, 5'd25);
        collect(0);
        n_cmp++;
        if (timed_out || got_data.size() != 25) begin
            n_err++;
            $display("FAIL bit_count: got %0d beats required 25", got_data.size());
        end
        for (int n = 0; n < got_data.size(); n++) begin
            e = (n == 1) ? 64'h1 : (n == 5) ? 64'h8000_0000_0000_0000 : 64'h0;
            n_cmp++;
            if (got_data[n] !== e) begin
                n_err++;
                $display("FAIL bit_beat%0d: got %h required %h", n, got_data[n], e);
            end
        end
    endtask

    task automatic test_truncation();
        int nls[6] = '{17, 0, 31, 1, 26, 0};
        st_t s;
        int cnt;
        nls[5] = $urandom_range(2, 24);
        for (int k = 0; k < 6; k++) begin
            s   = rand_state();
            cnt = clamp(nls[k]);
            do_load(s, 5'(nls[k]));
            collect(0);
            n_cmp++;
            if (timed_out || got_data.size() != cnt) begin
                n_err++;
                $display("FAIL trunc_count nl=%0d: got %0d beats required %0d", nls[k], got_data.size(), cnt);
            end
            for (int n = 0; n < got_data.size(); n++) begin
                n_cmp++;
                if (got_data[n] !== exp_lane(s, n) || got_idx[n] != n || got_last[n] != (n == cnt - 1)) begin
                    n_err++;
                    $display("FAIL trunc_beat nl=%0d n=%0d: got data=%h idx=%0d last=%0d required data=%h idx=%0d last=%0d",
                             nls[k], n, got_data[n], got_idx[n], got_last[n], exp_lane(s, n), n, (n == cnt - 1));
                end
            end
        end
    endtask

    task automatic test_backpressure();
        st_t s;
        int nl, cnt;
        for (int k = 0; k < 3; k++) begin
            s   = rand_state();
            nl  = $urandom_range(0, 31);
            cnt = clamp(nl);
            do_load(s, 5'(nl));
            collect(1);
            n_cmp++;
            if (timed_out || got_data.size() != cnt || stall_bad != 0) begin
                n_err++;
                $display("FAIL bp_stream nl=%0d: got %0d beats, %0d unstable stalls required %0d beats, 0",
                         nl, got_data.size(), stall_bad, cnt);
            end
            for (int n = 0; n < got_data.size(); n++) begin
                n_cmp++;
                if (got_data[n] !== exp_lane(s, n) || got_idx[n] != n) begin
                    n_err++;
                    $display("FAIL bp_beat%0d: got data=%h idx=%0d required data=%h idx=%0d",
                             n, got_data[n], got_idx[n], exp_lane(s, n), n);
                end
            end
        end
    endtask

    task automatic test_load_during_send();
        st_t a, b;
        int nb;
        a  = rand_state();
        b  = rand_state();
        nb = $urandom_range(1, 25);
        state_in   = a;
        num_lanes  = 5'd25;
        load_valid = 1'b1;
        @(negedge clk);
        state_in  = b;
        num_lanes = 5'(nb);
        collect(0);
        n_cmp++;
        if (timed_out || got_data.size() != 25 || lr_after !== 1'b1) begin
            n_err++;
            $display("FAIL lds_first: got %0d beats load_ready=%b required 25 beats load_ready=1",
                     got_data.size(), lr_after);
        end
        for (int n = 0; n < got_data.size(); n++) begin
            n_cmp++;
            if (got_data[n] !== exp_lane(a, n)) begin
                n_err++;
                $display("FAIL lds_a_beat%0d: got %h required %h", n, got_data[n], exp_lane(a, n));
            end
        end
        @(negedge clk);
        load_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b1 || out_index !== 5'd0) begin
            n_err++;
            $display("FAIL lds_second_start: got valid=%b idx=%0d required 1/0", out_valid, out_index);
        end
        collect(0);
        n_cmp++;
        if (timed_out || got_data.size() != nb) begin
            n_err++;
            $display("FAIL lds_second_count: got %0d beats required %0d", got_data.size(), nb);
        end
        for (int n = 0; n < got_data.size(); n++) begin
            n_cmp++;
            if (got_data[n] !== exp_lane(b, n) || got_idx[n] != n) begin
                n_err++;
                $display("FAIL lds_b_beat%0d: got data=%h idx=%0d required data=%h idx=%0d",
                         n, got_data[n], got_idx[n], exp_lane(b, n), n);
            end
        end
    endtask

    task automatic test_reset_mid();
        st_t s, s2;
        bit hit = 0;
        s  = rand_state();
        s2 = rand_state();
        do_load(s, 5'd25);
        out_ready = 1'b1;
        for (int c = 0; c < 40 && !hit; c++) begin
            if (out_valid && out_index == 5'd10) hit = 1;
            else @(negedge clk);
        end
        n_cmp++;
        if (!hit) begin
            n_err++;
            $display("FAIL rst_mid_reach: got no beat 10 required beat 10 within 40 cycles");
        end
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0 || out_data !== 64'h0 || busy !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_abort: got valid=%b data=%h busy=%b required 0/0/0", out_valid, out_data, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (load_ready !== 1'b1) begin
            n_err++;
            $display("FAIL rst_mid_ready: got load_ready=%b required 1", load_ready);
        end
        do_load(s2, 5'd25);
        collect(0);
        n_cmp++;
        if (timed_out || got_data.size() != 25) begin
            n_err++;
            $display("FAIL rst_mid_restart_count: got %0d beats required 25", got_data.size());
        end
        for (int n = 0; n < got_data.size(); n++) begin
            n_cmp++;
            if (got_data[n] !== exp_lane(s2, n) || got_idx[n] != n) begin
                n_err++;
                $display("FAIL rst_mid_beat%0d: got data=%h idx=%0d required data=%h idx=%0d",
                         n, got_data[n], got_idx[n], exp_lane(s2, n), n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_mapping();
        test_bit_order();
        test_truncation();
        test_backpressure();
        test_load_during_send();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
